coffee_dispense_ctrl: RTL and testbench

- Vending controller directly downstream of the coin counter.
- Consumes the running credit total, in units of 100, and accepts a drink selection and a start button.
- Checks credit against a per-drink price and drives the brew/dispense output for a fixed time.
- Then reports change and pulses a credit-clear request back to the coin stage. A cancel button refunds the full credit.

---
 rtl/coffee_dispense_ctrl.sv | 141 ++++++++++++++
 tb/tb_coffee_dispense_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/coffee_dispense_ctrl.sv
// Drink vending controller: checks coin credit against the selected drink price,
// times the dispense valve, then returns change and requests a credit clear.
module coffee_dispense_ctrl #(
  parameter int unsigned N           = 8,
  parameter int unsigned PRICE0      = 3,
  parameter int unsigned PRICE1      = 5,
  parameter int unsigned PRICE2      = 6,
  parameter int unsigned PRICE3      = 10,
  parameter int unsigned BREW_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] credit_i,
  input  logic [1:0]   sel_i,
  input  logic         start_i,
  input  logic         cancel_i,
  output logic         dispense_o,
  output logic [1:0]   drink_o,
  output logic         busy_o,
  output logic         deny_o,
  output logic [N-1:0] change_o,
  output logic         change_valid_o,
  output logic         clr_credit_o
);

  localparam int unsigned TW = (BREW_CYCLES > 1) ? $clog2(BREW_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    BREW   = 2'd2,
    CHANGE = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic           start_q, cancel_q;
  logic [1:0]     sel_q, sel_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           dispense_d, busy_d, deny_d, change_valid_d, clr_credit_d;
  logic [1:0]     drink_d;
  logic [N-1:0]   change_d;
  logic [N-1:0]   price_c;
  logic           start_e_c, cancel_e_c;

  assign start_e_c  = start_i & ~start_q;
  assign cancel_e_c = cancel_i & ~cancel_q;

  always_comb begin
    case (sel_q)
      2'd0:    price_c = N'(PRICE0);
      2'd1:    price_c = N'(PRICE1);
      2'd2:    price_c = N'(PRICE2);
      default: price_c = N'(PRICE3);
    endcase
  end

  // Outputs are computed from the next state so each registered output lines
  // up with the state it belongs to (change_valid directly follows dispense).
  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    timer_d        = timer_q;
    dispense_d     = 1'b0;
    drink_d        = 2'd0;
    deny_d         = 1'b0;
    change_d       = change_o;
    change_valid_d = 1'b0;
    clr_credit_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cancel_e_c) begin
          if (credit_i != '0) begin
            change_d       = credit_i;
            change_valid_d = 1'b1;
            clr_credit_d   = 1'b1;
          end
        end else if (start_e_c) begin
          sel_d   = sel_i;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (credit_i >= price_c) begin
          timer_d    = TW'(BREW_CYCLES - 1);
          state_d    = BREW;
          dispense_d = 1'b1;
          drink_d    = sel_q;
        end else begin
          deny_d  = 1'b1;
          state_d = IDLE;
        end
      end
      BREW: begin
        if (timer_q == '0) begin
          state_d        = CHANGE;
          change_d       = credit_i - price_c;
          change_valid_d = 1'b1;
          clr_credit_d   = 1'b1;
        end else begin
          timer_d    = timer_q - TW'(1);
          dispense_d = 1'b1;
          drink_d    = sel_q;
        end
      end
      CHANGE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      start_q        <= 1'b0;
      cancel_q       <= 1'b0;
      sel_q          <= 2'd0;
      timer_q        <= '0;
      dispense_o     <= 1'b0;
      drink_o        <= 2'd0;
      busy_o         <= 1'b0;
      deny_o         <= 1'b0;
      change_o       <= '0;
      change_valid_o <= 1'b0;
      clr_credit_o   <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_q        <= start_i;
      cancel_q       <= cancel_i;
      sel_q          <= sel_d;
      timer_q        <= timer_d;
      dispense_o     <= dispense_d;
      drink_o        <= drink_d;
      busy_o         <= busy_d;
      deny_o         <= deny_d;
      change_o       <= change_d;
      change_valid_o <= change_valid_d;
      clr_credit_o   <= clr_credit_d;
    end
  end

endmodule

// File: tb/tb_coffee_dispense_ctrl.sv
// Directed self-checking bench for coffee_dispense_ctrl with default parameters.
module tb_coffee_dispense_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] credit_i;
  logic [1:0] sel_i;
  logic       start_i;
  logic       cancel_i;
  logic       dispense_o;
  logic [1:0] drink_o;
  logic       busy_o;
  logic       deny_o;
  logic [7:0] change_o;
  logic       change_valid_o;
  logic       clr_credit_o;

  int checks;
  int errors;

  coffee_dispense_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .credit_i       (credit_i),
    .sel_i          (sel_i),
    .start_i        (start_i),
    .cancel_i       (cancel_i),
    .dispense_o     (dispense_o),
    .drink_o        (drink_o),
    .busy_o         (busy_o),
    .deny_o         (deny_o),
    .change_o       (change_o),
    .change_valid_o (change_valid_o),
    .clr_credit_o   (clr_credit_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a drink that is expected to succeed and check the whole transaction.
  task automatic brew(input logic [1:0] sel, input logic [7:0] cred,
                      input logic [7:0] bump, input logic [7:0] exp_change);
    credit_i = cred;
    sel_i    = sel;
    start_i  = 1'b1;
    tick();
    chk("chk_busy", 32'(busy_o), 32'd1);
    chk("chk_disp", 32'(dispense_o), 32'd0);
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("brew_disp", 32'(dispense_o), 32'd1);
      chk("brew_drink", 32'(drink_o), 32'(sel));
      chk("brew_cv", 32'(change_valid_o), 32'd0);
      if (i == 0 && bump != 8'd0) credit_i = bump;
    end
    tick();
    chk("chg_disp", 32'(dispense_o), 32'd0);
    chk("chg_drink", 32'(drink_o), 32'd0);
    chk("chg_cv", 32'(change_valid_o), 32'd1);
    chk("chg_clr", 32'(clr_credit_o), 32'd1);
    chk("chg_val", 32'(change_o), 32'(exp_change));
    tick();
    chk("post_busy", 32'(busy_o), 32'd0);
    chk("post_cv", 32'(change_valid_o), 32'd0);
    chk("post_chg", 32'(change_o), 32'(exp_change));
  endtask

  initial begin
    int ndisp;
    int ncv;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    credit_i = 8'd0;
    sel_i    = 2'd0;
    start_i  = 1'b0;
    cancel_i = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_disp", 32'(dispense_o), 32'd0);
    chk("rst_chg", 32'(change_o), 32'd0);
    rst = 1'b0;
    tick();

    // Exact credit on drink 1, then credit topped up during brew of drink 2.
    brew(2'd1, 8'd5, 8'd0, 8'd0);
    brew(2'd2, 8'd10, 8'd11, 8'd5);

    // Insufficient credit: deny pulse, no dispense, no clear.
    credit_i = 8'd2;
    sel_i    = 2'd0;
    start_i  = 1'b1;
    tick();
    chk("deny_chk_busy", 32'(busy_o), 32'd1);
    chk("deny_early", 32'(deny_o), 32'd0);
    start_i = 1'b0;
    tick();
    chk("deny_pulse", 32'(deny_o), 32'd1);
    chk("deny_disp", 32'(dispense_o), 32'd0);
    chk("deny_clr", 32'(clr_credit_o), 32'd0);
    chk("deny_busy", 32'(busy_o), 32'd0);
    tick();
    chk("deny_end", 32'(deny_o), 32'd0);
    chk("deny_cv", 32'(change_valid_o), 32'd0);

    // Cancel refund, then cancel with no credit.
    credit_i = 8'd7;
    cancel_i = 1'b1;
    tick();
    chk("cxl_cv", 32'(change_valid_o), 32'd1);
    chk("cxl_clr", 32'(clr_credit_o), 32'd1);
    chk("cxl_chg", 32'(change_o), 32'd7);
    chk("cxl_busy", 32'(busy_o), 32'd0);
    tick();
    chk("cxl_hold_cv", 32'(change_valid_o), 32'd0);
    chk("cxl_hold_chg", 32'(change_o), 32'd7);
    cancel_i = 1'b0;
    credit_i = 8'd0;
    tick();
    cancel_i = 1'b1;
    tick();
    chk("cxl0_cv", 32'(change_valid_o), 32'd0);
    chk("cxl0_clr", 32'(clr_credit_o), 32'd0);
    chk("cxl0_chg", 32'(change_o), 32'd7);
    cancel_i = 1'b0;
    tick();

    // Simultaneous start and cancel: cancel wins.
    credit_i = 8'd6;
    sel_i    = 2'd1;
    start_i  = 1'b1;
    cancel_i = 1'b1;
    tick();
    chk("both_cv", 32'(change_valid_o), 32'd1);
    chk("both_chg", 32'(change_o), 32'd6);
    chk("both_busy", 32'(busy_o), 32'd0);
    tick();
    chk("both_busy2", 32'(busy_o), 32'd0);
    start_i  = 1'b0;
    cancel_i = 1'b0;
    tick();

    // Start held high for 20 cycles: exactly one transaction.
    credit_i = 8'd3;
    sel_i    = 2'd0;
    start_i  = 1'b1;
    ndisp    = 0;
    ncv      = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dispense_o) ndisp++;
      if (change_valid_o) ncv++;
    end
    chk("held_disp_cnt", 32'(ndisp), 32'd4);
    chk("held_cv_cnt", 32'(ncv), 32'd1);
    chk("held_busy", 32'(busy_o), 32'd0);
    start_i = 1'b0;
    tick();

    // Reset on the second brew cycle.
    credit_i = 8'd5;
    sel_i    = 2'd1;
    start_i  = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    chk("mid_disp", 32'(dispense_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_disp", 32'(dispense_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_chg", 32'(change_o), 32'd0);
    chk("arst_cv", 32'(change_valid_o), 32'd0);
    chk("arst_clr", 32'(clr_credit_o), 32'd0);
    tick();
    rst = 1'b0;
    ndisp = 0;
    ncv   = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (dispense_o || busy_o || deny_o) ndisp++;
      if (change_valid_o || clr_credit_o) ncv++;
    end
    chk("after_rst_act", 32'(ndisp), 32'd0);
    chk("after_rst_pulse", 32'(ncv), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
